// File: rtl/axi_addr_fifo_fwft.sv
// axi_addr_fifo_fwft: first-word-fall-through FIFO (register array, registered read into a 2-entry output stage) with count, almost-full, flush and sticky overflow/underflow flags
module axi_addr_fifo_fwft #(
  parameter int FIFO_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 32,
  parameter int FIFO_CNT_WID = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_init,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIFO_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIFO_WIDTH-1:0]   out_data,
  input  logic [FIFO_CNT_WID-1:0] afull_thresh,
  output logic                    afull,
  output logic [FIFO_CNT_WID-1:0] word_cnt,
  output logic                    ovf_err,
  output logic                    udf_err,
  input  logic                    clr_err
);
  localparam int AW = FIFO_CNT_WID - 1;
  localparam logic [FIFO_CNT_WID-1:0] DEPTH_C = FIFO_CNT_WID'(FIFO_DEPTH);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_CNT_WID-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, rd_data;
  logic [1:0] s_cnt_q, s_cnt_d, s_kept;
  logic ovf_q, ovf_d, udf_q, udf_d, push, pop, rd_en;
  assign in_ready  = cnt_q < DEPTH_C;
  assign out_valid = s_cnt_q != 2'd0;
  assign out_data  = s0_q;
  assign afull     = cnt_q >= afull_thresh;
  assign word_cnt  = cnt_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;
  assign push      = in_valid && in_ready && !fifo_init;
  assign pop       = out_valid && out_ready && !fifo_init;
  assign s_kept    = s_cnt_q - {1'b0, pop};
  assign rd_en     = (wr_ptr_q != rd_ptr_q) && (s_kept != 2'd2) && !fifo_init;
  assign rd_data   = mem[rd_ptr_q[AW-1:0]];
  always_comb begin
    wr_ptr_d = fifo_init ? '0 : wr_ptr_q + FIFO_CNT_WID'(push);
    rd_ptr_d = fifo_init ? '0 : rd_ptr_q + FIFO_CNT_WID'(rd_en);
    cnt_d    = fifo_init ? '0 : cnt_q + FIFO_CNT_WID'(push) - FIFO_CNT_WID'(pop);
    s0_d     = fifo_init ? '0 : (rd_en && s_kept == 2'd0) ? rd_data : pop ? s1_q : s0_q;
    s1_d     = fifo_init ? '0 : (rd_en && s_kept == 2'd1) ? rd_data : s1_q;
    s_cnt_d  = fifo_init ? 2'd0 : s_kept + {1'b0, rd_en};
    ovf_d    = fifo_init ? ovf_q : (in_valid && !in_ready) || (ovf_q && !clr_err);
    udf_d    = fifo_init ? udf_q : (out_ready && !out_valid) || (udf_q && !clr_err);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q[AW-1:0]] <= in_data;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      s_cnt_q  <= 2'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s_cnt_q  <= s_cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
endmodule

// File: tb/tb_axi_addr_fifo_fwft.sv
// tb_axi_addr_fifo_fwft: randomized and directed checks of the FWFT FIFO against a queue-based reference model
module tb_axi_addr_fifo_fwft;
  logic clk = 0, rst_n = 0, fifo_init = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic afull, ovf_err, udf_err, clr_err = 0;
  logic [63:0] in_data = '0, out_data;
  logic [5:0] afull_thresh = 6'd24, word_cnt;
  int vec = 0, miss = 0, now = 0;
  bit m_ovf = 0, m_udf = 0;
  typedef struct { logic [63:0] d; int t; } ent_t;
  ent_t q[$];
  always #5 clk = ~clk;
  axi_addr_fifo_fwft dut (
    .clk(clk), .rst_n(rst_n), .fifo_init(fifo_init), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .afull_thresh(afull_thresh), .afull(afull), .word_cnt(word_cnt), .ovf_err(ovf_err),
    .udf_err(udf_err), .clr_err(clr_err)
  );
  function automatic bit m_vld();
    if (q.size() == 0) return 0;
    return q[0].t <= now - 2;
  endfunction
  task automatic step(input bit iv, input logic [63:0] d, input bit ordy,
                      input bit init = 0, input bit clr = 0, input bit rn = 1);
    bit rdy, vld;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; fifo_init = init; clr_err = clr; rst_n = rn;
    rdy = q.size() < 32;
    vld = m_vld();
    if (!rn) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else if (init) q.delete();
    else begin
      m_ovf = (iv && !rdy) || (m_ovf && !clr);
      m_udf = (ordy && !vld) || (m_udf && !clr);
      if (ordy && vld) void'(q.pop_front());
      if (iv && rdy) q.push_back('{d, now});
    end
    @(posedge clk);
    now++;
    #1;
  endtask
  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    vec++; if (word_cnt !== 6'd0) begin miss++; $display("FAIL reset_cnt got %0d want 0", word_cnt); end
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_ovalid got %b want 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL reset_iready got %b want 1", in_ready); end
    vec++; if (out_data !== 64'd0) begin miss++; $display("FAIL reset_odata got %h want 0", out_data); end
    vec++; if ({ovf_err, udf_err} !== 2'b00) begin miss++; $display("FAIL reset_err got %b want 00", {ovf_err, udf_err}); end
  endtask
  task automatic test_first_word();
    step(1, 64'hA5, 0);
    vec++; if (word_cnt !== 6'd1) begin miss++; $display("FAIL fw_cnt got %0d want 1", word_cnt); end
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL fw_early got %b want 0", out_valid); end
    step(0, 0, 0);
    vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL fw_valid got %b want 1", out_valid); end
    vec++; if (out_data !== 64'hA5) begin miss++; $display("FAIL fw_data got %h want a5", out_data); end
    step(0, 0, 1);
    vec++; if (word_cnt !== 6'd0) begin miss++; $display("FAIL fw_pop_cnt got %0d want 0", word_cnt); end
  endtask
  task automatic test_fill();
    for (int i = 0; i < 32; i++) step(1, 64'(i), 0);
    vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL full_iready got %b want 0", in_ready); end
    vec++; if (word_cnt !== 6'd32) begin miss++; $display("FAIL full_cnt got %0d want 32", word_cnt); end
    step(1, 64'hDEAD, 1);
    vec++; if (ovf_err !== 1'b1) begin miss++; $display("FAIL full_ovf got %b want 1", ovf_err); end
    vec++; if (word_cnt !== 6'd31) begin miss++; $display("FAIL full_nopass got %0d want 31", word_cnt); end
    for (int i = 1; i < 32; i++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== 64'(i)) begin
        miss++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 64'(i));
      end
      step(0, 0, 1);
    end
    vec++; if (word_cnt !== 6'd0 || out_valid !== 1'b0) begin miss++; $display("FAIL drain_end got cnt=%0d v=%b want 0 0", word_cnt, out_valid); end
  endtask
  task automatic test_init();
    for (int i = 0; i < 10; i++) step(1, 64'(100 + i), 0);
    step(0, 0, 0);
    step(1, 64'h77, 0, 1);
    vec++; if (word_cnt !== 6'd0) begin miss++; $display("FAIL init_cnt got %0d want 0", word_cnt); end
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL init_ovalid got %b want 0", out_valid); end
    vec++; if (ovf_err !== 1'b1) begin miss++; $display("FAIL init_ovf got %b want 1", ovf_err); end
    step(1, 64'h55, 0);
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL init_p1 got %b want 0", out_valid); end
    step(0, 0, 0);
    vec++; if (out_valid !== 1'b1 || out_data !== 64'h55) begin miss++; $display("FAIL init_p2 got v=%b d=%h want 1 55", out_valid, out_data); end
    step(0, 0, 1, 0, 1);
    vec++; if (ovf_err !== 1'b0 || word_cnt !== 6'd0) begin miss++; $display("FAIL init_clr got ovf=%b cnt=%0d want 0 0", ovf_err, word_cnt); end
  endtask
  task automatic test_afull();
    afull_thresh = 6'd24;
    for (int i = 0; i < 23; i++) step(1, 64'(i), 0);
    vec++; if (afull !== 1'b0) begin miss++; $display("FAIL afull_23 got %b want 0", afull); end
    step(1, 64'd23, 0);
    vec++; if (afull !== 1'b1) begin miss++; $display("FAIL afull_24 got %b want 1", afull); end
    step(0, 0, 1);
    vec++; if (afull !== 1'b0) begin miss++; $display("FAIL afull_fall got %b want 0", afull); end
    afull_thresh = 6'd0; #1;
    vec++; if (afull !== 1'b1) begin miss++; $display("FAIL afull_t0 got %b want 1", afull); end
    afull_thresh = 6'd33; #1;
    vec++; if (afull !== 1'b0) begin miss++; $display("FAIL afull_t33 got %b want 0", afull); end
    afull_thresh = 6'd24;
    step(0, 0, 0, 1);
  endtask
  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      step($urandom_range(0, 99) < 60, {$urandom, $urandom}, $urandom_range(0, 99) < 50);
      vec++;
      if (word_cnt !== 6'(q.size()) || in_ready !== (q.size() < 32) || out_valid !== m_vld()
          || afull !== (q.size() >= 24) || ovf_err !== m_ovf || udf_err !== m_udf) begin
        miss++;
        $display("FAIL rand_%0d state got cnt=%0d rdy=%b v=%b af=%b ovf=%b udf=%b want cnt=%0d rdy=%b v=%b af=%b ovf=%b udf=%b",
                 c, word_cnt, in_ready, out_valid, afull, ovf_err, udf_err,
                 q.size(), q.size() < 32, m_vld(), q.size() >= 24, m_ovf, m_udf);
      end
      if (m_vld()) begin
        vec++;
        if (out_data !== q[0].d) begin miss++; $display("FAIL rand_%0d data got %h want %h", c, out_data, q[0].d); end
      end
    end
  endtask
  task automatic test_errors();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    vec++; if (udf_err !== 1'b1) begin miss++; $display("FAIL udf_set got %b want 1", udf_err); end
    step(0, 0, 0, 0, 1);
    vec++; if (udf_err !== 1'b0) begin miss++; $display("FAIL udf_clr got %b want 0", udf_err); end
    for (int i = 0; i < 5; i++) step(1, 64'(i + 9), i > 2);
    step(1, 64'h3, 1, 0, 0, 0);
    vec++;
    if (word_cnt !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      miss++;
      $display("FAIL mid_reset got cnt=%0d v=%b rdy=%b d=%h ovf=%b udf=%b want 0 0 1 0 0 0", word_cnt, out_valid, in_ready, out_data, ovf_err, udf_err);
    end
  endtask
  initial begin
    test_reset();
    test_first_word();
    test_fill();
    test_init();
    test_afull();
    test_random();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
